// File: rtl/serial_mac_pkg.sv
// Shared types and default widths for the serial multiply-accumulate unit.
package serial_mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL,
        ACC,
        SHOUT,
        DONE
    } mac_state_e;

    localparam int DEF_OP_W  = 8;
    localparam int DEF_ACC_W = 2 * DEF_OP_W + 4;

endpackage

// File: rtl/shift_add_mult.sv
// Unsigned shift-add multiplier: operands load on go, then OP_W add/shift steps
// produce the exact 2*OP_W-bit product; ready stays high until the next go.
module shift_add_mult #(
    parameter int OP_W = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                go,
    input  logic [OP_W-1:0]     op_a,
    input  logic [OP_W-1:0]     op_b,
    output logic [2*OP_W-1:0]   product,
    output logic                ready
);

    localparam int CNT_W = $clog2(OP_W + 1);
    localparam logic [CNT_W-1:0] STEPS   = CNT_W'(OP_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2*OP_W-1:0] mcand_q, mcand_d;
    logic [OP_W-1:0]   mplier_q, mplier_d;
    logic [2*OP_W-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              ready_q, ready_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        ready_d  = ready_q;
        if (go) begin
            mcand_d  = (2*OP_W)'(op_a);
            mplier_d = op_b;
            prod_d   = '0;
            cnt_d    = STEPS;
            run_d    = 1'b1;
            ready_d  = 1'b0;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                run_d   = 1'b0;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            ready_q  <= ready_d;
        end
    end

    assign product = prod_q;
    assign ready   = ready_q;

endmodule

// File: rtl/serial_mac_unit.sv
// Bit-serial multiply-accumulate: shifts in A/B LSB first, multiplies, folds the
// product into the accumulator, then streams the accumulator out LSB first.
module serial_mac_unit
    import serial_mac_pkg::*;
#(
    parameter int OP_W  = DEF_OP_W,
    parameter int ACC_W = 2 * OP_W + 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic acc_en,
    input  logic clear_acc,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic out_bit,
    output logic out_valid,
    output logic done,
    output logic carry_out
);

    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] OP_LAST  = CNT_W'(OP_W - 1);
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACC_W - 1);

    mac_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              carry_q, carry_d;
    logic              acc_en_q, acc_en_d;
    logic              busy_q, busy_d;
    logic              out_bit_q, out_bit_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;

    logic              mult_go;
    logic              mult_ready;
    logic [2*OP_W-1:0] mult_product;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W:0]    sum;

    // The last LOAD edge hands the fully assembled operands straight to the multiplier.
    assign mult_go  = (state_q == LOAD) && (cnt_q == OP_LAST);
    assign prod_ext = ACC_W'(mult_product);
    assign sum      = {1'b0, acc_q} + {1'b0, prod_ext};

    shift_add_mult #(
        .OP_W(OP_W)
    ) u_mult (
        .clock   (clock),
        .reset_n (reset_n),
        .go      (mult_go),
        .op_a    (a_d),
        .op_b    (b_d),
        .product (mult_product),
        .ready   (mult_ready)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        acc_en_d    = acc_en_q;
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_acc) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                end
                if (start) begin
                    state_d  = LOAD;
                    acc_en_d = acc_en;
                    cnt_d    = '0;
                end
            end
            LOAD: begin
                a_d   = {a_bit, a_q[OP_W-1:1]};
                b_d   = {b_bit, b_q[OP_W-1:1]};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == OP_LAST) begin
                    state_d = MUL;
                    cnt_d   = '0;
                end
            end
            MUL: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == OP_LAST) begin
                    state_d = ACC;
                    cnt_d   = '0;
                end
            end
            ACC: begin
                if (mult_ready) begin
                    acc_d = acc_en_q ? sum[ACC_W-1:0] : prod_ext;
                    if (acc_en_q && sum[ACC_W]) begin
                        carry_d = 1'b1;
                    end
                    state_d = SHOUT;
                end
            end
            SHOUT: begin
                // Rotating rather than shifting leaves the accumulator intact after readout.
                out_valid_d = 1'b1;
                out_bit_d   = acc_q[0];
                acc_d       = {acc_q[0], acc_q[ACC_W-1:1]};
                cnt_d       = cnt_q + CNT_ONE;
                if (cnt_q == ACC_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            acc_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            acc_en_q    <= acc_en_d;
            busy_q      <= busy_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign carry_out = carry_q;

endmodule
